// File: rtl/servo_pkg.sv
// Shared defaults, types and helpers for the servo slew controller.
package servo_pkg;

  localparam int unsigned DUTYWIDTH_DEF = 10;
  localparam int unsigned DUTYLOW_DEF   = 52;
  localparam int unsigned DUTYHIGH_DEF  = 102;

  typedef logic [DUTYWIDTH_DEF-1:0] duty_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } servo_state_e;

  function automatic logic [31:0] clamp_u(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_target_reg.sv
// Commanded target register: load > (sweep toggle) > step pulses, clamped to the end stops.
// With SERVO_SWEEP_EN defined, sweep_mode_i auto-toggles the target between end stops while idle.
module servo_target_reg
  import servo_pkg::*;
#(
  parameter int unsigned DUTYLOW     = DUTYLOW_DEF,
  parameter int unsigned DUTYHIGH    = DUTYHIGH_DEF,
  parameter int unsigned DUTYWIDTH   = DUTYWIDTH_DEF,
  parameter int unsigned TARGET_STEP = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_i,
  input  logic [DUTYWIDTH-1:0] load_value_i,
  input  logic                 step_up_i,
  input  logic                 step_dn_i,
`ifdef SERVO_SWEEP_EN
  input  logic                 sweep_mode_i,
  input  logic                 idle_i,
  input  logic [DUTYWIDTH-1:0] duty_i,
`endif
  output logic [DUTYWIDTH-1:0] target_o,
  output logic [DUTYWIDTH-1:0] target_d_o
);

  localparam int unsigned XW = DUTYWIDTH + 1;

  logic [DUTYWIDTH-1:0] target_q, target_d;
  logic [XW-1:0]        tgt_x, up_x, dn_x;

  // One extra bit keeps the +step sum from wrapping before the clamp.
  always_comb begin
    tgt_x    = {1'b0, target_q};
    up_x     = tgt_x + XW'(TARGET_STEP);
    dn_x     = tgt_x - XW'(TARGET_STEP);
    target_d = target_q;
    if (load_i) begin
      target_d = DUTYWIDTH'(clamp_u(32'(load_value_i), DUTYLOW, DUTYHIGH));
    end
`ifdef SERVO_SWEEP_EN
    else if (sweep_mode_i) begin
      if (idle_i) begin
        target_d = (duty_i == DUTYWIDTH'(DUTYLOW)) ? DUTYWIDTH'(DUTYHIGH) : DUTYWIDTH'(DUTYLOW);
      end
    end
`endif
    else if (step_up_i && !step_dn_i) begin
      target_d = DUTYWIDTH'(clamp_u(32'(up_x), DUTYLOW, DUTYHIGH));
    end
    else if (step_dn_i && !step_up_i) begin
      target_d = (tgt_x < XW'(TARGET_STEP)) ? DUTYWIDTH'(DUTYLOW)
                                            : DUTYWIDTH'(clamp_u(32'(dn_x), DUTYLOW, DUTYHIGH));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      target_q <= DUTYWIDTH'(DUTYLOW);
    end else begin
      target_q <= target_d;
    end
  end

  assign target_o   = target_q;
  assign target_d_o = target_d;

endmodule

// File: rtl/servo_slew_controller.sv
// Slews the applied PWM duty toward the commanded target, one DUTYSTEP per SLEW_FRAMES frames.
// Optional macro SERVO_SWEEP_EN adds the sweep_mode input (end-stop to end-stop auto sweep).
//   state     | meaning
//   IDLE      | duty == target, frame counter held at 0
//   RAMP_UP   | duty below target, stepping up on slew updates
//   RAMP_DOWN | duty above target, stepping down on slew updates
module servo_slew_controller
  import servo_pkg::*;
#(
  parameter int unsigned DUTYLOW     = DUTYLOW_DEF,
  parameter int unsigned DUTYHIGH    = DUTYHIGH_DEF,
  parameter int unsigned DUTYSTEP    = 1,
  parameter int unsigned DUTYWIDTH   = DUTYWIDTH_DEF,
  parameter int unsigned TARGET_STEP = 5,
  parameter int unsigned SLEW_FRAMES = 2
) (
  input  logic                 CLK,
  input  logic                 CPU_RESETN,
  input  logic                 frame_tick,
  input  logic                 step_up,
  input  logic                 step_dn,
  input  logic                 load,
  input  logic [DUTYWIDTH-1:0] load_value,
`ifdef SERVO_SWEEP_EN
  input  logic                 sweep_mode,
`endif
  output logic [DUTYWIDTH-1:0] duty,
  output logic [DUTYWIDTH-1:0] target,
  output logic                 busy,
  output logic                 arrived
);

  localparam int unsigned XW = DUTYWIDTH + 1;
  localparam int unsigned CW = (SLEW_FRAMES > 1) ? $clog2(SLEW_FRAMES) : 1;

  servo_state_e         state_q;
  logic [DUTYWIDTH-1:0] duty_q, duty_d, duty_slew;
  logic [DUTYWIDTH-1:0] target_q, target_d;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q, arrived_q;
  logic                 ramping, dir_up, cnt_last, slew_fire;
  logic [XW-1:0]        gap_x;

  servo_target_reg #(
    .DUTYLOW    (DUTYLOW),
    .DUTYHIGH   (DUTYHIGH),
    .DUTYWIDTH  (DUTYWIDTH),
    .TARGET_STEP(TARGET_STEP)
  ) u_target (
    .clk_i       (CLK),
    .rst_n_i     (CPU_RESETN),
    .load_i      (load),
    .load_value_i(load_value),
    .step_up_i   (step_up),
    .step_dn_i   (step_dn),
`ifdef SERVO_SWEEP_EN
    .sweep_mode_i(sweep_mode),
    .idle_i      (state_q == IDLE),
    .duty_i      (duty_q),
`endif
    .target_o    (target_q),
    .target_d_o  (target_d)
  );

  // Step direction comes from the live target, so a retarget mid-ramp never moves duty away.
  always_comb begin
    ramping   = (state_q != IDLE);
    dir_up    = (target_q > duty_q);
    cnt_last  = (cnt_q == CW'(SLEW_FRAMES - 1));
    slew_fire = ramping && frame_tick && cnt_last && (target_q != duty_q);
    gap_x     = dir_up ? ({1'b0, target_q} - {1'b0, duty_q})
                       : ({1'b0, duty_q} - {1'b0, target_q});
    if (gap_x < XW'(DUTYSTEP)) begin
      duty_slew = target_q;
    end else if (dir_up) begin
      duty_slew = duty_q + DUTYWIDTH'(DUTYSTEP);
    end else begin
      duty_slew = duty_q - DUTYWIDTH'(DUTYSTEP);
    end
    duty_d = slew_fire ? duty_slew : duty_q;
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q   <= IDLE;
      duty_q    <= DUTYWIDTH'(DUTYLOW);
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      arrived_q <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      busy_q    <= (duty_d != target_d);
      arrived_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (target_q > duty_q)      state_q <= RAMP_UP;
          else if (target_q < duty_q) state_q <= RAMP_DOWN;
        end
        RAMP_UP, RAMP_DOWN: begin
          if (target_q == duty_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            if (frame_tick) cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
            if (slew_fire && (duty_slew == target_q)) begin
              state_q   <= IDLE;
              arrived_q <= 1'b1;
            end else begin
              state_q <= dir_up ? RAMP_UP : RAMP_DOWN;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign duty    = duty_q;
  assign target  = target_q;
  assign busy    = busy_q;
  assign arrived = arrived_q;

endmodule

// File: tb/tb_servo_slew_controller.sv
// Self-checking bench for servo_slew_controller: directed scenarios plus random stimulus vs a reference model.
module tb_servo_slew_controller;

  localparam int LOW   = 52;
  localparam int HIGH  = 102;
  localparam int TSTEP = 5;
  localparam int SF    = 2;
  localparam int W     = 10;

  logic         CLK = 1'b0;
  logic         CPU_RESETN = 1'b1;
  logic         frame_tick = 1'b0, step_up = 1'b0, step_dn = 1'b0, load = 1'b0;
  logic [W-1:0] load_value = '0;
`ifdef SERVO_SWEEP_EN
  logic         sweep_mode = 1'b0;
`endif
  logic [W-1:0] duty_a, target_a, duty_b, target_b;
  logic         busy_a, arr_a, busy_b, arr_b;

  int checks = 0;
  int failures = 0;

  // Reference model state per instance (0: DUTYSTEP=1, 1: DUTYSTEP=4)
  int m_t[2], m_d[2], m_c[2];
  bit m_mv[2], m_arr[2], m_busy[2];

  always #5 CLK = ~CLK;

  servo_slew_controller u_dut_a (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .frame_tick(frame_tick),
    .step_up(step_up), .step_dn(step_dn), .load(load), .load_value(load_value),
`ifdef SERVO_SWEEP_EN
    .sweep_mode(sweep_mode),
`endif
    .duty(duty_a), .target(target_a), .busy(busy_a), .arrived(arr_a)
  );

  servo_slew_controller #(.DUTYSTEP(4)) u_dut_b (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .frame_tick(frame_tick),
    .step_up(step_up), .step_dn(step_dn), .load(load), .load_value(load_value),
`ifdef SERVO_SWEEP_EN
    .sweep_mode(sweep_mode),
`endif
    .duty(duty_b), .target(target_b), .busy(busy_b), .arrived(arr_b)
  );

  function automatic int stepof(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int clampi(input int v);
    return (v < LOW) ? LOW : ((v > HIGH) ? HIGH : v);
  endfunction

  always @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int k = 0; k < 2; k++) begin
        m_t[k] <= LOW; m_d[k] <= LOW; m_c[k] <= 0;
        m_mv[k] <= 1'b0; m_arr[k] <= 1'b0; m_busy[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int t, d, nt, nd, nc;
        bit nmv, narr;
        t = m_t[k]; d = m_d[k];
        if (load) nt = clampi(int'(load_value));
`ifdef SERVO_SWEEP_EN
        else if (sweep_mode) nt = m_mv[k] ? t : ((d == LOW) ? HIGH : LOW);
`endif
        else if (step_up && !step_dn) nt = (t + TSTEP > HIGH) ? HIGH : t + TSTEP;
        else if (step_dn && !step_up) nt = (t - TSTEP < LOW) ? LOW : t - TSTEP;
        else nt = t;
        nd = d; nc = m_c[k]; nmv = m_mv[k]; narr = 1'b0;
        if (!m_mv[k]) begin
          nc = 0; nmv = (t != d);
        end else if (t == d) begin
          nc = 0; nmv = 1'b0;
        end else if (frame_tick) begin
          if (m_c[k] == SF - 1) begin
            nc = 0;
            if (t > d) nd = (t - d < stepof(k)) ? t : d + stepof(k);
            else       nd = (d - t < stepof(k)) ? t : d - stepof(k);
            if (nd == t) begin nmv = 1'b0; narr = 1'b1; end
          end else begin
            nc = m_c[k] + 1;
          end
        end
        m_t[k] <= nt; m_d[k] <= nd; m_c[k] <= nc;
        m_mv[k] <= nmv; m_arr[k] <= narr; m_busy[k] <= (nd != nt);
      end
    end
  end

  task automatic cyc(input bit ft);
    frame_tick = ft;
    @(posedge CLK);
    @(negedge CLK);
    frame_tick = 1'b0; step_up = 1'b0; step_dn = 1'b0; load = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < 600) begin
      cyc(1'b1);
      n++;
    end
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL %s_settle: busy_a=%0b busy_b=%0b after %0d cycles, want 0", tag, busy_a, busy_b, n);
    end
  endtask

  task automatic test_reset();
    CPU_RESETN = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (duty_a !== 10'd52 || target_a !== 10'd52 || busy_a !== 1'b0 || arr_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_held_a: duty=%0d target=%0d busy=%0b arrived=%0b, want 52 52 0 0", duty_a, target_a, busy_a, arr_a);
    end
    checks++;
    if (duty_b !== 10'd52 || target_b !== 10'd52 || busy_b !== 1'b0 || arr_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_held_b: duty=%0d target=%0d busy=%0b arrived=%0b, want 52 52 0 0", duty_b, target_b, busy_b, arr_b);
    end
    CPU_RESETN = 1'b1;
    cyc(1'b1);
    checks++;
    if (duty_a !== 10'd52 || target_a !== 10'd52 || busy_a !== 1'b0 || arr_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: duty=%0d target=%0d busy=%0b arrived=%0b, want 52 52 0 0", duty_a, target_a, busy_a, arr_a);
    end
  endtask

  task automatic test_step_ramp();
    int ticks, hit, arrs;
    logic [W-1:0] prev;
    ticks = 0; hit = -1; arrs = 0;
    for (int i = 0; i < 3; i++) begin step_up = 1'b1; cyc(1'b0); end
    checks++;
    if (target_a !== 10'd67) begin
      failures++; $display("FAIL step3_target: got %0d, want 67", target_a);
    end
    prev = duty_a;
    for (int i = 0; i < 80; i++) begin
      bit ft;
      ft = i[0];
      if (ft) ticks++;
      cyc(ft);
      if (arr_a) arrs++;
      checks++;
      if (duty_a !== W'(m_d[0]) || busy_a !== m_busy[0] || arr_a !== m_arr[0]) begin
        failures++;
        $display("FAIL ramp_model cyc %0d: duty=%0d busy=%0b arrived=%0b, want %0d %0b %0b", i, duty_a, busy_a, arr_a, m_d[0], m_busy[0], m_arr[0]);
      end
      checks++;
      if (duty_a < prev || duty_a > prev + 1) begin
        failures++; $display("FAIL ramp_step cyc %0d: duty %0d after %0d, want +0 or +1", i, duty_a, prev);
      end
      if (duty_a == 10'd67 && hit < 0) begin
        hit = ticks;
        checks++;
        if (busy_a !== 1'b0 || arr_a !== 1'b1) begin
          failures++; $display("FAIL ramp_arrive_flags: busy=%0b arrived=%0b, want 0 1", busy_a, arr_a);
        end
      end
      prev = duty_a;
    end
    checks++;
    if (hit != 30) begin
      failures++; $display("FAIL ramp_ticks: reached 67 after %0d ticks, want 30", hit);
    end
    checks++;
    if (arrs != 1) begin
      failures++; $display("FAIL ramp_arrived_count: got %0d, want 1", arrs);
    end
    checks++;
    if (duty_b !== 10'd67 || target_b !== 10'd67 || busy_b !== 1'b0) begin
      failures++; $display("FAIL ramp_step4_final: duty=%0d target=%0d busy=%0b, want 67 67 0", duty_b, target_b, busy_b);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      step_up = 1'b1; cyc(1'b1);
      checks++;
      if (duty_a < LOW || duty_a > HIGH || duty_a !== W'(m_d[0])) begin
        failures++; $display("FAIL sat_up_duty cyc %0d: got %0d, want %0d in 52..102", i, duty_a, m_d[0]);
      end
    end
    checks++;
    if (target_a !== 10'd102) begin
      failures++; $display("FAIL sat_high_target: got %0d, want 102", target_a);
    end
    for (int i = 0; i < 25; i++) begin
      step_dn = 1'b1; cyc(1'b1);
      checks++;
      if (duty_a < LOW || duty_a > HIGH || duty_a !== W'(m_d[0])) begin
        failures++; $display("FAIL sat_dn_duty cyc %0d: got %0d, want %0d in 52..102", i, duty_a, m_d[0]);
      end
    end
    checks++;
    if (target_a !== 10'd52) begin
      failures++; $display("FAIL sat_low_target: got %0d, want 52", target_a);
    end
    settle("saturate");
    checks++;
    if (duty_a !== 10'd52) begin
      failures++; $display("FAIL sat_final_duty: got %0d, want 52", duty_a);
    end
  endtask

  task automatic test_simultaneous();
    load_value = 10'd77; load = 1'b1; cyc(1'b0);
    checks++;
    if (target_a !== 10'd77) begin
      failures++; $display("FAIL load77: got %0d, want 77", target_a);
    end
    step_up = 1'b1; step_dn = 1'b1; cyc(1'b0);
    checks++;
    if (target_a !== 10'd77 || target_b !== 10'd77) begin
      failures++; $display("FAIL up_and_dn: got %0d/%0d, want 77", target_a, target_b);
    end
    load_value = 10'd200; load = 1'b1; step_dn = 1'b1; cyc(1'b0);
    checks++;
    if (target_a !== 10'd102) begin
      failures++; $display("FAIL load_beats_dn: got %0d, want 102", target_a);
    end
    settle("simul");
    checks++;
    if (duty_a !== 10'd102 || duty_b !== 10'd102) begin
      failures++; $display("FAIL simul_final_duty: got %0d/%0d, want 102", duty_a, duty_b);
    end
  endtask

  task automatic test_midramp_load();
    int n, arrs;
    logic [W-1:0] prev;
    load_value = 10'd52; load = 1'b1; cyc(1'b0);
    settle("mid_pre");
    load_value = 10'd80; load = 1'b1; cyc(1'b0);
    n = 0;
    while (duty_a != 10'd60 && n < 100) begin cyc(1'b1); n++; end
    checks++;
    if (duty_a !== 10'd60) begin
      failures++; $display("FAIL mid_reach60: duty=%0d after %0d cycles, want 60", duty_a, n);
    end
    load_value = 10'd55; load = 1'b1; cyc(1'b0);
    checks++;
    if (target_a !== 10'd55) begin
      failures++; $display("FAIL mid_load55: got %0d, want 55", target_a);
    end
    arrs = 0; prev = duty_a;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1);
      if (arr_a) arrs++;
      checks++;
      if (duty_a < 55 || duty_a > prev) begin
        failures++; $display("FAIL mid_descent cyc %0d: duty %0d after %0d, want 55..%0d", i, duty_a, prev, prev);
      end
      prev = duty_a;
    end
    checks++;
    if (duty_a !== 10'd55 || arrs != 1) begin
      failures++; $display("FAIL mid_final: duty=%0d arrivals=%0d, want 55 and 1", duty_a, arrs);
    end
  endtask

  task automatic test_dutystep4();
    int seen[$];
    int exp_seq[3];
    exp_seq = '{52, 56, 57};
    load_value = 10'd52; load = 1'b1; cyc(1'b0);
    settle("step4_pre");
    step_up = 1'b1; cyc(1'b0);
    checks++;
    if (target_b !== 10'd57) begin
      failures++; $display("FAIL step4_target: got %0d, want 57", target_b);
    end
    seen.push_back(int'(duty_b));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      if (int'(duty_b) != seen[$]) seen.push_back(int'(duty_b));
    end
    checks++;
    if (seen.size() != 3) begin
      failures++; $display("FAIL step4_count: got %0d distinct duties, want 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen[i] != exp_seq[i]) begin
          failures++; $display("FAIL step4_seq[%0d]: got %0d, want %0d", i, seen[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    load_value = 10'd90; load = 1'b1; cyc(1'b0);
    repeat (8) cyc(1'b1);
    #2;
    CPU_RESETN = 1'b0;
    #1;
    checks++;
    if (duty_a !== 10'd52 || target_a !== 10'd52 || busy_a !== 1'b0) begin
      failures++; $display("FAIL async_reset_a: duty=%0d target=%0d busy=%0b, want 52 52 0", duty_a, target_a, busy_a);
    end
    checks++;
    if (duty_b !== 10'd52 || target_b !== 10'd52 || busy_b !== 1'b0) begin
      failures++; $display("FAIL async_reset_b: duty=%0d target=%0d busy=%0b, want 52 52 0", duty_b, target_b, busy_b);
    end
    @(negedge CLK);
    CPU_RESETN = 1'b1;
    cyc(1'b1);
    checks++;
    if (duty_a !== 10'd52 || busy_a !== 1'b0 || arr_a !== 1'b0) begin
      failures++; $display("FAIL async_reset_after: duty=%0d busy=%0b arrived=%0b, want 52 0 0", duty_a, busy_a, arr_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      load       = ($urandom_range(0, 15) == 0);
      load_value = W'($urandom_range(0, 1023));
      step_up    = ($urandom_range(0, 5) == 0);
      step_dn    = ($urandom_range(0, 5) == 0);
      cyc($urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) begin
        logic [W-1:0] dv, tv;
        logic bv, av;
        dv = (k == 0) ? duty_a : duty_b;
        tv = (k == 0) ? target_a : target_b;
        bv = (k == 0) ? busy_a : busy_b;
        av = (k == 0) ? arr_a : arr_b;
        checks++;
        if (dv !== W'(m_d[k]) || tv !== W'(m_t[k]) || bv !== m_busy[k] || av !== m_arr[k]) begin
          failures++;
          $display("FAIL random dut%0d cyc %0d: duty=%0d target=%0d busy=%0b arrived=%0b, want %0d %0d %0b %0b",
                   k, i, dv, tv, bv, av, m_d[k], m_t[k], m_busy[k], m_arr[k]);
        end
      end
    end
  endtask

`ifdef SERVO_SWEEP_EN
  task automatic test_sweep();
    int arrs;
    bit hit_hi, back_lo;
    arrs = 0; hit_hi = 1'b0; back_lo = 1'b0;
    sweep_mode = 1'b1;
    CPU_RESETN = 1'b0;
    @(negedge CLK);
    CPU_RESETN = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1);
      if (arr_a) arrs++;
      if (duty_a == 10'd102) hit_hi = 1'b1;
      if (hit_hi && duty_a == 10'd52) back_lo = 1'b1;
      checks++;
      if (duty_a !== W'(m_d[0]) || target_a !== W'(m_t[0]) || arr_a !== m_arr[0]) begin
        failures++;
        $display("FAIL sweep_model cyc %0d: duty=%0d target=%0d arrived=%0b, want %0d %0d %0b", i, duty_a, target_a, arr_a, m_d[0], m_t[0], m_arr[0]);
      end
    end
    checks++;
    if (!hit_hi || !back_lo || arrs < 2) begin
      failures++; $display("FAIL sweep_cycle: hit_high=%0b back_low=%0b arrivals=%0d, want 1 1 >=2", hit_hi, back_lo, arrs);
    end
    sweep_mode = 1'b0;
    settle("sweep");
  endtask
`endif

  initial begin
    test_reset();
    test_step_ramp();
    test_saturate();
    test_simultaneous();
    test_midramp_load();
    test_dutystep4();
    test_async_reset();
    test_random();
`ifdef SERVO_SWEEP_EN
    test_sweep();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
